// File: rtl/fp_add_norm_round.sv
// fp_add_norm_round
// Back half of the mini floating-point adder. Takes the larger operand and the
// aligned smaller mantissa from the alignment shifter, adds or subtracts them,
// normalises one bit per cycle, rounds half-up on the guard bit and packs
// {sign, exp, frac} (bias 7, hidden 1, no denormals).
//
// Ports
//   CLK, RST_N             clock (rising edge), asynchronous active-low reset
//   IN_VALID / IN_READY    operand bundle handshake (IN_READY high only when idle)
//   OP_SUB                 1 = effective subtraction
//   BIG_SIGN/EXP/FRAC      larger-exponent operand
//   SHIFT_FRAC             aligned smaller mantissa {hidden, frac, guard}
//   OUT_VALID / OUT_READY  result handshake; result and flags held until accepted
//   RESULT                 packed sum
//   OVF, UNF, ZERO         saturated overflow, flushed underflow, exact zero
module fp_add_norm_round #(
  parameter int unsigned EXP_W  = 4,
  parameter int unsigned FRAC_W = 4
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic                      OP_SUB,
  input  logic                      BIG_SIGN,
  input  logic [EXP_W-1:0]          BIG_EXP,
  input  logic [FRAC_W-1:0]         BIG_FRAC,
  input  logic [FRAC_W+1:0]         SHIFT_FRAC,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [EXP_W+FRAC_W:0]     RESULT,
  output logic                      OVF,
  output logic                      UNF,
  output logic                      ZERO
);

  localparam int unsigned MW = FRAC_W + 2;          // {hidden, frac, guard}
  localparam int unsigned SW = FRAC_W + 3;          // sum with carry
  localparam int unsigned EW = EXP_W + 1;           // exponent with overflow headroom
  localparam int unsigned RW = 1 + EXP_W + FRAC_W;

  localparam logic [EW-1:0] E_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EW-1:0] E_ONE = EW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   m_q, m_d;      // holds A until ADD, then the working mantissa
  logic [MW-1:0]   b_q, b_d;
  logic [EW-1:0]   e_q, e_d;
  logic            s_q, s_d;
  logic            sub_q, sub_d;
  logic [RW-1:0]   res_q, res_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            zero_q, zero_d;

  logic [SW-1:0]   sum;
  logic [FRAC_W:0] f_rnd;
  logic [EW-1:0]   e_rnd;

  always_comb begin
    sum   = sub_q ? ({1'b0, m_q} - {1'b0, b_q}) : ({1'b0, m_q} + {1'b0, b_q});
    f_rnd = {1'b0, m_q[FRAC_W:1]} + {{FRAC_W{1'b0}}, m_q[0]};
    // a carry out of the rounded fraction leaves it all-zero, exponent bumps
    e_rnd = f_rnd[FRAC_W] ? (e_q + E_ONE) : e_q;
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    b_d     = b_q;
    e_d     = e_q;
    s_d     = s_q;
    sub_d   = sub_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    zero_d  = zero_q;

    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          m_d     = {1'b1, BIG_FRAC, 1'b0};
          b_d     = SHIFT_FRAC;
          e_d     = {1'b0, BIG_EXP};
          s_d     = BIG_SIGN;
          sub_d   = OP_SUB;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        if (!sub_q && sum[SW-1]) begin
          // carry: shift right, keep the dropped bit sticky in the guard
          m_d = {sum[SW-1:2], sum[1] | sum[0]};
          e_d = e_q + E_ONE;
        end else if (sub_q && (b_q > m_q)) begin
          m_d = b_q - m_q;
          s_d = ~s_q;
        end else begin
          m_d = sum[MW-1:0];
        end
        state_d = S_NORM;
      end

      S_NORM: begin
        if (m_q == '0) begin
          zero_d  = 1'b1;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          res_d   = '0;
          state_d = S_DONE;
        end else if (m_q[MW-1]) begin
          state_d = S_ROUND;
        end else if (e_q == '0) begin
          unf_d   = 1'b1;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          res_d   = '0;
          state_d = S_DONE;
        end else begin
          m_d = m_q << 1;
          e_d = e_q - E_ONE;
        end
      end

      S_ROUND: begin
        zero_d = 1'b0;
        unf_d  = 1'b0;
        if (e_rnd > E_MAX) begin
          ovf_d = 1'b1;
          res_d = {s_q, {(EXP_W + FRAC_W){1'b1}}};
        end else begin
          ovf_d = 1'b0;
          res_d = {s_q, e_rnd[EXP_W-1:0], f_rnd[FRAC_W-1:0]};
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        if (OUT_READY) begin
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      b_q     <= '0;
      e_q     <= '0;
      s_q     <= 1'b0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      b_q     <= b_d;
      e_q     <= e_d;
      s_q     <= s_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      zero_q  <= zero_d;
    end
  end

  assign IN_READY  = (state_q == S_IDLE);
  assign OUT_VALID = (state_q == S_DONE);
  assign RESULT    = res_q;
  assign OVF       = ovf_q;
  assign UNF       = unf_q;
  assign ZERO      = zero_q;

endmodule

// File: tb/tb_fp_add_norm_round.sv
// tb_fp_add_norm_round
// Directed-vector bench for fp_add_norm_round. An arithmetic model predicts the
// packed result, flags and latency of each accepted operation; a compare
// process checks the outputs on every cycle OUT_VALID is high.
module tb_fp_add_norm_round;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic       OP_SUB = 1'b0;
  logic       BIG_SIGN = 1'b0;
  logic [3:0] BIG_EXP = '0;
  logic [3:0] BIG_FRAC = '0;
  logic [5:0] SHIFT_FRAC = '0;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b1;
  logic [8:0] RESULT;
  logic       OVF, UNF, ZERO;

  fp_add_norm_round #(.EXP_W(4), .FRAC_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OP_SUB(OP_SUB), .BIG_SIGN(BIG_SIGN), .BIG_EXP(BIG_EXP),
    .BIG_FRAC(BIG_FRAC), .SHIFT_FRAC(SHIFT_FRAC),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RESULT(RESULT), .OVF(OVF), .UNF(UNF), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  typedef struct {
    logic [8:0]  res;
    logic        ovf;
    logic        unf;
    logic        zero;
    int unsigned lat;
    int unsigned t_acc;
  } exp_t;

  exp_t exq[$];
  bit   seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Value-level model: mantissas as integers scaled so the hidden bit is 32.
  function automatic exp_t model(input bit sub, input bit sg, input logic [3:0] ex,
                                 input logic [3:0] fr, input logic [5:0] sh);
    exp_t r;
    int a, b, m, e, k, q;
    bit s;
    a = (16 + int'(fr)) * 2;
    b = int'(sh);
    e = int'(ex);
    s = sg;
    m = sub ? a - b : a + b;
    if (m < 0) begin
      m = -m;
      s = ~s;
    end
    r.res = '0; r.ovf = 1'b0; r.unf = 1'b0; r.zero = 1'b0; r.t_acc = 0;
    if (m >= 64) begin
      m = (m / 2) | (m % 2);
      e = e + 1;
    end
    if (m == 0) begin
      r.zero = 1'b1;
      r.lat  = 2;
      return r;
    end
    k = 0;
    while (m < 32) begin
      m = m * 2;
      k++;
    end
    if (k > e) begin
      r.unf = 1'b1;
      r.lat = 2 + e;
      return r;
    end
    e = e - k;
    r.lat = 3 + k;
    q = m / 2 + m % 2;                 // round half up on the guard half-unit
    if (q == 32) begin
      q = 16;
      e = e + 1;
    end
    if (e > 15) begin
      r.ovf = 1'b1;
      r.res = {s, 8'hFF};
    end else begin
      r.res = {s, 4'(e), 4'(q - 16)};
    end
    return r;
  endfunction

  // Compare process
  always @(negedge CLK) begin
    exp_t h;
    if (!RST_N) begin
      exq.delete();
      seen = 1'b0;
    end else if (OUT_VALID) begin
      if (exq.size() == 0) begin
        chk("unexpected_out_valid", 32'(OUT_VALID), 32'd0);
      end else begin
        h = exq[0];
        chk("result", 32'(RESULT), 32'(h.res));
        chk("ovf", 32'(OVF), 32'(h.ovf));
        chk("unf", 32'(UNF), 32'(h.unf));
        chk("zero", 32'(ZERO), 32'(h.zero));
        chk("in_ready_busy", 32'(IN_READY), 32'd0);
        if (!seen) begin
          chk("latency", cyc, h.t_acc + h.lat);
          seen = 1'b1;
        end
        if (OUT_READY) begin
          void'(exq.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic do_op(input bit sub, input bit sg, input logic [3:0] ex, input logic [3:0] fr,
                       input logic [5:0] sh, input bit pin, input logic [8:0] pres,
                       input bit povf, input bit punf, input bit pzero, input int unsigned plat);
    exp_t e;
    int unsigned n;
    n = 0;
    @(negedge CLK);
    while (!IN_READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!IN_READY) begin
      chk("in_ready_timeout", 32'(IN_READY), 32'd1);
      return;
    end
    e = model(sub, sg, ex, fr, sh);
    e.t_acc = cyc + 1;
    if (pin) begin
      chk("model_result", 32'(e.res), 32'(pres));
      chk("model_flags", {29'd0, e.ovf, e.unf, e.zero}, {29'd0, povf, punf, pzero});
      chk("model_latency", e.lat, plat);
    end
    OP_SUB = sub; BIG_SIGN = sg; BIG_EXP = ex; BIG_FRAC = fr; SHIFT_FRAC = sh;
    IN_VALID = 1'b1;
    exq.push_back(e);
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    while (exq.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (exq.size() != 0) begin
      chk("completion_timeout", exq.size(), 0);
      exq.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(IN_READY), 32'd1);
    chk({tag, "_out_valid"}, 32'(OUT_VALID), 32'd0);
    chk({tag, "_result"}, 32'(RESULT), 32'd0);
    chk({tag, "_flags"}, {29'd0, OVF, UNF, ZERO}, 32'd0);
  endtask

  typedef struct {
    bit sub; bit sg; logic [3:0] ex; logic [3:0] fr; logic [5:0] sh;
  } vec_t;

  initial begin
    vec_t extra[$];
    int unsigned n;

    repeat (3) @(negedge CLK);
    chk_reset_outputs("reset");
    RST_N = 1'b1;

    //     sub sg ex  fr     sh          pin res     ovf unf zero lat
    do_op(0, 0, 7, 4'h0, 6'b100000, 1, 9'h080, 0, 0, 0, 3);   // 1.0 + 1.0
    do_op(1, 0, 7, 4'h8, 6'b101000, 1, 9'h050, 0, 0, 0, 5);   // 1.5 - 1.25
    do_op(1, 0, 7, 4'h0, 6'b100000, 1, 9'h000, 0, 0, 1, 2);   // cancellation
    do_op(0, 0, 15, 4'hF, 6'b111110, 1, 9'h0FF, 1, 0, 0, 3);  // overflow
    do_op(0, 0, 7, 4'hF, 6'b000001, 1, 9'h080, 0, 0, 0, 3);   // round carry
    do_op(1, 0, 7, 4'h0, 6'b110000, 1, 9'h160, 0, 0, 0, 4);   // B > A, sign flips
    do_op(1, 0, 1, 4'h0, 6'b011111, 1, 9'h000, 0, 1, 0, 3);   // underflow
    do_op(0, 1, 3, 4'h1, 6'b100001, 1, 9'h141, 0, 0, 0, 3);   // sticky guard on carry
    wait_idle();

    extra.push_back('{0, 1, 10, 4'h5, 6'b010011});
    extra.push_back('{1, 0, 12, 4'h3, 6'b100111});
    extra.push_back('{0, 0, 0, 4'h0, 6'b000000});
    extra.push_back('{1, 1, 2, 4'h9, 6'b011000});
    extra.push_back('{1, 0, 9, 4'h2, 6'b000011});
    foreach (extra[i])
      do_op(extra[i].sub, extra[i].sg, extra[i].ex, extra[i].fr, extra[i].sh,
            0, 9'h000, 0, 0, 0, 0);
    wait_idle();

    // Backpressure: result must stay put while OUT_READY is low
    OUT_READY = 1'b0;
    do_op(0, 1, 7, 4'h0, 6'b100000, 1, 9'h180, 0, 0, 0, 3);
    n = 0;
    while (!OUT_VALID && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("backpressure_valid", 32'(OUT_VALID), 32'd1);
    repeat (5) @(negedge CLK);
    chk("backpressure_in_ready", 32'(IN_READY), 32'd0);
    chk("backpressure_result", 32'(RESULT), 32'h180);
    OUT_READY = 1'b1;
    wait_idle();

    // Reset while normalising: 32 - 31 needs five shifts
    do_op(1, 0, 7, 4'h0, 6'b011111, 0, 9'h000, 0, 0, 0, 0);
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1 chk_reset_outputs("midop_reset");
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    chk("flushed_queue", exq.size(), 0);

    do_op(0, 0, 7, 4'h0, 6'b100000, 1, 9'h080, 0, 0, 0, 3);
    wait_idle();
    repeat (2) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
